adder_accumulator: RTL and testbench
====================================

ADDER_ACCUMULATOR -- requirements
Module: adder_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter NUM_OPERANDS, default 4, giving the operands summed per transaction; legal range 1..256.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset. Ports:
  clk  input  1  rising-edge clock
  rst_n  input  1  asynchronous active-low reset
  in_valid  input  1  operand is valid
  in_ready  output  1  block accepts an operand this cycle
  operand  input  WIDTH  operand value, unsigned
  out_valid  output  1  result/carry_out are valid
  out_ready  input  1  consumer takes the result this cycle
  result  output  WIDTH  sum of the transaction's operands
  carry_out  output  1  sticky overflow flag for the transaction
  busy  output  1  transaction in progress (state != IDLE)

Function
REQ-004 The FSM SHALL have states IDLE, ACCUM and DONE.
REQ-005 An operand SHALL be accepted only on a rising clk edge with in_valid=1 and in_ready=1.
REQ-006 in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE. out_valid SHALL be 1 only in DONE.
REQ-007 In IDLE, an accept SHALL load acc=operand, clear carry and set count=1. The FSM SHALL then go to ACCUM, or to DONE if NUM_OPERANDS=1.
REQ-008 In ACCUM, an accept SHALL compute {c,acc}=acc+operand (WIDTH+1-bit add), OR c into carry and increment count.
REQ-009 When that accept makes count equal NUM_OPERANDS, the FSM SHALL go to DONE on the same edge.
REQ-010 out_valid SHALL rise on the clock edge that accepts the final operand, so it is visible in the cycle after the last operand is presented.
REQ-011 In DONE, result and carry_out SHALL hold stable until out_ready=1. The handshake edge SHALL return the FSM to IDLE.
REQ-012 A cycle with in_valid=0 in IDLE or ACCUM SHALL leave the state, acc, count and carry unchanged. Gaps between operands are legal.
REQ-013 Without saturation, result SHALL equal the sum modulo 2^WIDTH. carry_out SHALL be 1 if any partial sum exceeded 2^WIDTH-1.
REQ-014 in_valid asserted in DONE SHALL be ignored. No operand is accepted on the out handshake edge; the next transaction starts in IDLE.
REQ-015 result and carry_out SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-016 On rst_n=0, asynchronously, the block SHALL set state=IDLE, acc=0, count=0, carry=0, result=0, carry_out=0, out_valid=0 and busy=0; in_ready then reads 1.
REQ-017 Reset asserted mid-transaction SHALL discard all partial state. The first accept after reset release SHALL start a fresh transaction.

Configuration
REQ-018 The block SHALL use macro ADDER_ACCUMULATOR_SATURATE_EN to select saturation.
REQ-019 With the macro defined, once carry is set, acc SHALL hold MAX_VALUE=2^WIDTH-1 for the rest of the transaction, so result=MAX_VALUE and carry_out=1.
REQ-020 With the macro undefined, the block SHALL use wrap-around behaviour per REQ-013 and instantiate no saturation logic.

Structure
REQ-021 Package adder_pkg SHALL hold the FSM state typedef (enum logic [1:0] IDLE/ACCUM/DONE) and a function max_value(width) returning 2^width-1.
REQ-022 Count width SHALL be $clog2(NUM_OPERANDS+1).
REQ-023 The add SHALL instantiate one existing combinational sub-module, adder_2_inputs #(WIDTH), producing result and carry_out from a and b. All sequential logic SHALL stay in adder_accumulator.

Verification (WIDTH=4, NUM_OPERANDS=4 unless stated)
REQ-024 Operands 1,2,3,4 back-to-back with out_ready=1 -> out_valid one cycle after the 4th accept, result=10, carry_out=0, FSM in IDLE next cycle.
REQ-025 Operands 15,15,15,15 -> macro undefined: result=12, carry_out=1; macro defined: result=15, carry_out=1.
REQ-026 Operands 0,0,0,0 with in_valid dropped for 3 cycles between the 2nd and 3rd operand -> result=0, carry_out=0, busy=1 throughout the gap.
REQ-027 Operands 7,7,1,0 with out_ready=0 for 5 cycles, in_valid=1 held with operand=9 -> result=15 stable, in_ready=0, the 9 is not absorbed; after the handshake the next transaction starts with 9.
REQ-028 rst_n pulsed low after 2 of operands 8,8,8,8, then 1,1,1,1 -> all outputs 0 during reset, then result=4, carry_out=0.
REQ-029 NUM_OPERANDS=1, operand 13 -> out_valid on the next cycle, result=13, carry_out=0, ACCUM never entered.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the adder_accumulator slice.
//   state_t   : accumulator FSM encoding (IDLE / ACCUM / DONE)
//   max_value : all-ones value of a given bit width (2^width - 1), up to 64 bits
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [63:0] max_value(input int unsigned width);
    if (width >= 64) return '1;
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/adder_2_inputs.sv
// Combinational two-input unsigned adder.
//   a, b      : WIDTH-bit unsigned addends
//   result    : low WIDTH bits of a + b
//   carry_out : bit WIDTH of a + b
module adder_2_inputs #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  always_comb begin
    {carry_out, result} = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/adder_accumulator.sv
// Sums NUM_OPERANDS unsigned operands per transaction over a valid/ready
// input stream and presents the sum plus a sticky overflow flag over a
// valid/ready output handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (ready low while a result waits)
//   operand             : WIDTH-bit unsigned operand
//   out_valid/out_ready : result handshake; handshake edge returns to IDLE
//   result, carry_out   : registered sum and sticky overflow flag
//   busy                : transaction in progress
// Build option: define ADDER_ACCUMULATOR_SATURATE_EN to clamp the sum at
// 2^WIDTH-1 once an overflow has occurred; default build wraps.
module adder_accumulator
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned NUM_OPERANDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             busy
);

  localparam int unsigned CW = $clog2(NUM_OPERANDS + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_OPERANDS);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] add_sum;
  logic             add_c;
  logic [WIDTH-1:0] acc_next;

  adder_2_inputs #(.WIDTH(WIDTH)) u_add (
    .a         (acc),
    .b         (operand),
    .result    (add_sum),
    .carry_out (add_c)
  );

`ifdef ADDER_ACCUMULATOR_SATURATE_EN
  localparam logic [WIDTH-1:0] MAX_VALUE = WIDTH'(max_value(WIDTH));

  // Clamp on the overflowing add itself and on every add after it.
  always_comb begin
    acc_next = (carry | add_c) ? MAX_VALUE : add_sum;
  end
`else
  always_comb begin
    acc_next = add_sum;
  end
`endif

  always_comb begin
    count_next = count + 1'b1;
  end

  assign in_ready  = (state != DONE);
  assign result    = acc;
  assign carry_out = carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      carry     <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= operand;
            carry <= 1'b0;
            count <= CW'(1);
            busy  <= 1'b1;
            if (NUM_OPERANDS == 1) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc   <= acc_next;
            carry <= carry | add_c;
            count <= count_next;
            if (count_next == LAST) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_accumulator.sv
// Self-checking bench for adder_accumulator (WIDTH=4, NUM_OPERANDS=4) plus a
// NUM_OPERANDS=1 instance. A transaction-level model (running total and
// operand count) predicts outputs every cycle; directed cases pin literals.
module tb_adder_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] operand = '0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, carry_out, busy;
  logic [3:0] result;

  logic       in_valid2 = 1'b0;
  logic [3:0] operand2 = '0;
  logic       out_ready2 = 1'b1;
  logic       in_ready2, out_valid2, carry_out2, busy2;
  logic [3:0] result2;

  int unsigned tests = 0;
  int unsigned fails = 0;
  bit          accum_seen2 = 1'b0;

  // transaction-level model of the 4-operand instance
  int unsigned m_total = 0;
  int unsigned m_n = 0;
  bit          m_done = 1'b0;

`ifdef ADDER_ACCUMULATOR_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  adder_accumulator #(.WIDTH(4), .NUM_OPERANDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operand(operand), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .busy(busy)
  );

  adder_accumulator #(.WIDTH(4), .NUM_OPERANDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .operand(operand2), .out_valid(out_valid2), .out_ready(out_ready2),
    .result(result2), .carry_out(carry_out2), .busy(busy2)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned model_result();
    if (SAT && m_total > 15) return 15;
    return m_total % 16;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_total = 0; m_n = 0; m_done = 1'b0;
    end else if (m_done) begin
      if (out_ready) begin
        m_total = 0; m_n = 0; m_done = 1'b0;
      end
    end else if (in_valid) begin
      m_total += int'(operand);
      m_n++;
      if (m_n == 4) m_done = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("model_out_valid", 32'(out_valid), m_done ? 1 : 0);
    check("model_in_ready", 32'(in_ready), m_done ? 0 : 1);
    check("model_busy", 32'(busy), (m_done || m_n > 0) ? 1 : 0);
    if (m_done) begin
      check("model_result", 32'(result), model_result());
      check("model_carry", 32'(carry_out), (m_total > 15) ? 1 : 0);
    end
    if (rst_n && busy2 && !out_valid2) accum_seen2 = 1'b1;
  end

  task automatic push(input logic [3:0] v);
    int unsigned waited = 0;
    in_valid = 1'b1;
    operand  = v;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    @(negedge clk);
    check("rst_result", 32'(result), 0);
    check("rst_carry", 32'(carry_out), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1+2+3+4
    push(4'd1); push(4'd2); push(4'd3); push(4'd4);
    @(negedge clk);
    check("sum10_out_valid", 32'(out_valid), 1);
    check("sum10_result", 32'(result), 10);
    check("sum10_carry", 32'(carry_out), 0);
    @(negedge clk);
    check("sum10_idle_busy", 32'(busy), 0);
    check("sum10_idle_in_ready", 32'(in_ready), 1);
    idle_cycle();

    // 15 x4 overflow
    push(4'd15); push(4'd15); push(4'd15); push(4'd15);
    @(negedge clk);
    check("ovf_result", 32'(result), SAT ? 15 : 12);
    check("ovf_carry", 32'(carry_out), 1);
    idle_cycle();

    // zeros with a 3-cycle gap
    push(4'd0); push(4'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("gap_busy", 32'(busy), 1);
      idle_cycle();
    end
    push(4'd0); push(4'd0);
    @(negedge clk);
    check("zero_result", 32'(result), 0);
    check("zero_carry", 32'(carry_out), 0);
    idle_cycle();

    // output back-pressure with a pending operand 9
    out_ready = 1'b0;
    push(4'd7); push(4'd7); push(4'd1); push(4'd0);
    in_valid = 1'b1;
    operand  = 4'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_result", 32'(result), 15);
      check("hold_carry", 32'(carry_out), 0);
      check("hold_in_ready", 32'(in_ready), 0);
      check("hold_out_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    push(4'd9); push(4'd1); push(4'd1); push(4'd1);
    @(negedge clk);
    check("after_hold_result", 32'(result), 12);
    check("after_hold_carry", 32'(carry_out), 0);
    idle_cycle();

    // reset mid-transaction
    push(4'd8); push(4'd8);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_result", 32'(result), 0);
    check("midrst_carry", 32'(carry_out), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_out_valid", 32'(out_valid), 0);
    idle_cycle();
    rst_n = 1'b1;
    push(4'd1); push(4'd1); push(4'd1); push(4'd1);
    @(negedge clk);
    check("postrst_result", 32'(result), 4);
    check("postrst_carry", 32'(carry_out), 0);
    idle_cycle();

    // single-operand instance
    in_valid2 = 1'b1;
    operand2  = 4'd13;
    @(negedge clk);
    check("n1_in_ready", 32'(in_ready2), 1);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    @(negedge clk);
    check("n1_out_valid", 32'(out_valid2), 1);
    check("n1_result", 32'(result2), 13);
    check("n1_carry", 32'(carry_out2), 0);
    check("n1_done_in_ready", 32'(in_ready2), 0);
    @(negedge clk);
    check("n1_idle_busy", 32'(busy2), 0);
    idle_cycle();

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      operand   = 4'($urandom);
      out_ready = ($urandom_range(2) != 0);
      idle_cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) idle_cycle();

    check("n1_accum_never_entered", 32'(accum_seen2), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
